// File: rtl/apu_req_queue_pkg.sv
// Shared types for the APU request queue: one packed request type used by
// both the storage array and the accelerator-facing payload.
package apu_req_queue_pkg;

  typedef struct packed {
    logic [2:0][31:0] operands;
    logic [5:0]       op;
    logic [14:0]      flags;
  } apu_req_t;

endpackage

// File: rtl/apu_req_fifo_mem.sv
// DEPTH-entry register array for queued APU requests; async read, no data reset.
module apu_req_fifo_mem
  import apu_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  apu_req_t      i_wdata,
  input  logic [AW-1:0] i_raddr,
  output apu_req_t      o_rdata
);

  apu_req_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apu_req_queue.sv
// In-order APU request queue between the core and the accelerator, with an
// outstanding-request limit and a registered result return path.
module apu_req_queue
  import apu_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 1,
  localparam int unsigned PtrW           = $clog2(DEPTH),
  localparam int unsigned CntW           = PtrW + 1
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             core_req_i,
  output logic             core_gnt_o,
  input  logic [2:0][31:0] core_operands_i,
  input  logic [5:0]       core_op_i,
  input  logic [14:0]      core_flags_i,
  output logic             core_rvalid_o,
  output logic [31:0]      core_result_o,
  output logic [4:0]       core_flags_o,
  output logic             acc_req_o,
  input  logic             acc_gnt_i,
  output logic [2:0][31:0] acc_operands_o,
  output logic [5:0]       acc_op_o,
  output logic [14:0]      acc_flags_o,
  input  logic             acc_rvalid_i,
  input  logic [31:0]      acc_result_i,
  input  logic [4:0]       acc_flags_i,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o
);

  localparam logic [1:0] MaxOut = 2'(MAX_OUTSTANDING);

  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0] r_count, w_count_d;
  logic [1:0]      r_outst, w_outst_d;
  logic            r_err, w_err_d;
  logic            r_rvalid;
  logic [31:0]     r_result;
  logic [4:0]      r_rflags;

  logic     w_full, w_empty, w_push, w_pop;
  apu_req_t w_wdata, w_head, w_acc;

  assign w_full  = (r_count == CntW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = core_req_i & ~w_full;
  // A result returning this cycle frees its slot for an immediate reissue.
  assign acc_req_o = ~w_empty & ((r_outst < MaxOut) | ((r_outst == MaxOut) & acc_rvalid_i));
  assign w_pop     = acc_req_o & acc_gnt_i;
  assign w_wdata   = {core_operands_i, core_op_i, core_flags_i};

  apu_req_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  // Mask the unreset storage so the payload reads zero while idle or in reset.
  assign w_acc          = w_empty ? '0 : w_head;
  assign acc_operands_o = w_acc.operands;
  assign acc_op_o       = w_acc.op;
  assign acc_flags_o    = w_acc.flags;

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CntW'(1);
      2'b01:   w_count_d = r_count - CntW'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_comb begin
    w_outst_d = r_outst;
    w_err_d   = r_err;
    if (w_pop && !acc_rvalid_i) begin
      w_outst_d = r_outst + 2'd1;
    end else if (!w_pop && acc_rvalid_i) begin
      if (r_outst == 2'd0) begin
        w_err_d = 1'b1;
      end else begin
        w_outst_d = r_outst - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_outst  <= '0;
      r_err    <= 1'b0;
      r_rvalid <= 1'b0;
      r_result <= '0;
      r_rflags <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count  <= w_count_d;
      r_outst  <= w_outst_d;
      r_err    <= w_err_d;
      r_rvalid <= acc_rvalid_i;
      if (acc_rvalid_i) begin
        r_result <= acc_result_i;
        r_rflags <= acc_flags_i;
      end
    end
  end

  assign core_gnt_o    = w_push;
  assign core_rvalid_o = r_rvalid;
  assign core_result_o = r_result;
  assign core_flags_o  = r_rflags;
  assign count_o       = r_count;
  assign full_o        = w_full;
  assign empty_o       = w_empty;
  assign err_o         = r_err;

endmodule
